// File: rtl/time_pkg.sv
// Shared types and constants for the wall-clock time keeper.
package time_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } set_state_e;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;

  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = 8;
  localparam int HOUR_LSB = 16;

  function automatic set_state_e next_set_state(input set_state_e s);
    case (s)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return RUN;
    endcase
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up counter with synchronous load and clear; carry flags the wrap.
module wrap_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         Rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  assign carry = inc && (q == TOP);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == TOP) ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 1 Hz time base with hour/min/sec counters, key-driven setting and bulk load.
// All control inputs are single-cycle pulses; sec_tick and load_err are single-cycle registered pulses.
module time_keeper
  import time_pkg::*;
#(
  parameter int SYSCLKHZ = 50_000_000,
  parameter int HOURS    = 24
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic        key_mode_p,
  input  logic        key_inc_p,
  input  logic        load_en,
  input  logic [23:0] load_data,
  output logic [23:0] time_data,
  output logic        sec_tick,
  output logic [1:0]  set_state,
  output logic        load_err
);

  localparam int PW = (SYSCLKHZ > 1) ? $clog2(SYSCLKHZ) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(SYSCLKHZ - 1);

  set_state_e    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    hour;
  logic [5:0]    minute, second;
  logic [7:0]    ld_hour, ld_min, ld_sec;
  logic          load_ok, load_go, inc_go, tick_hit, tick_go;
  logic          sec_carry, min_carry, hour_carry;
  logic          sec_clr, min_inc, hour_inc;

  assign ld_hour = load_data[HOUR_LSB +: 8];
  assign ld_min  = load_data[MIN_LSB +: 8];
  assign ld_sec  = load_data[SEC_LSB +: 8];

  assign load_ok  = (ld_hour < 8'(HOURS)) && (ld_min < 8'(MIN_MOD)) && (ld_sec < 8'(SEC_MOD));
  assign load_go  = load_en && load_ok;
  assign inc_go   = key_inc_p && !key_mode_p && !load_en;
  assign tick_hit = (state_q == RUN) && En && (pre_q == PRE_TC);
  // Any load (legal or not) or a mode key swallows a coincident tick.
  assign tick_go  = tick_hit && !load_en && !key_mode_p;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    if (load_en) begin
      if (load_ok) begin
        state_d = RUN;
        pre_d   = '0;
      end
    end else if (key_mode_p) begin
      state_d = next_set_state(state_q);
      pre_d   = '0;
    end else if (state_q != RUN) begin
      pre_d = '0;
    end else if (En) begin
      pre_d = (pre_q == PRE_TC) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= RUN;
      pre_q    <= '0;
      sec_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      sec_tick <= tick_go;
      load_err <= load_en && !load_ok;
    end
  end

  // Manual increments never ripple: hour only follows a minute wrap caused by a tick.
  assign sec_clr  = inc_go && (state_q == SET_SEC);
  assign min_inc  = sec_carry || (inc_go && (state_q == SET_MIN));
  assign hour_inc = (sec_carry && min_carry) || (inc_go && (state_q == SET_HOUR));

  wrap_counter #(.MOD(SEC_MOD), .W(6)) u_sec (
    .clk(clk), .Rst_n(Rst_n), .inc(tick_go), .clr(sec_clr), .ld(load_go),
    .ld_val(ld_sec[5:0]), .q(second), .carry(sec_carry)
  );

  wrap_counter #(.MOD(MIN_MOD), .W(6)) u_min (
    .clk(clk), .Rst_n(Rst_n), .inc(min_inc), .clr(1'b0), .ld(load_go),
    .ld_val(ld_min[5:0]), .q(minute), .carry(min_carry)
  );

  wrap_counter #(.MOD(HOURS), .W(5)) u_hour (
    .clk(clk), .Rst_n(Rst_n), .inc(hour_inc), .clr(1'b0), .ld(load_go),
    .ld_val(ld_hour[4:0]), .q(hour), .carry(hour_carry)
  );

  hour_wrap_at_top: assert property (@(posedge clk) disable iff (!Rst_n)
    hour_carry |-> (hour == 5'(HOURS - 1)));

  assign time_data = {3'b000, hour, 2'b00, minute, 2'b00, second};
  assign set_state = state_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at SYSCLKHZ=10: tick timing, carries, set FSM, load and reset.
module tb_time_keeper;

  localparam int CLK_HZ = 10;

  logic        clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        En = 1'b0;
  logic        key_mode_p = 1'b0;
  logic        key_inc_p = 1'b0;
  logic        load_en = 1'b0;
  logic [23:0] load_data = '0;

  logic [23:0] time_data, time12;
  logic        sec_tick, tick12;
  logic [1:0]  set_state, state12;
  logic        load_err, err12;

  int n_vec = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic        mode;
    logic        inc;
    logic        load;
    logic [23:0] data;
    logic [23:0] exp_time;
    logic [1:0]  exp_state;
    logic        exp_err;
  } vec_t;

  vec_t vecs[22];

  time_keeper #(.SYSCLKHZ(CLK_HZ), .HOURS(24)) dut (
    .clk(clk), .Rst_n(Rst_n), .En(En), .key_mode_p(key_mode_p), .key_inc_p(key_inc_p),
    .load_en(load_en), .load_data(load_data), .time_data(time_data),
    .sec_tick(sec_tick), .set_state(set_state), .load_err(load_err)
  );

  time_keeper #(.SYSCLKHZ(CLK_HZ), .HOURS(12)) dut12 (
    .clk(clk), .Rst_n(Rst_n), .En(En), .key_mode_p(key_mode_p), .key_inc_p(key_inc_p),
    .load_en(load_en), .load_data(load_data), .time_data(time12),
    .sec_tick(tick12), .set_state(state12), .load_err(err12)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i, input logic l, input logic [23:0] d);
    key_mode_p = m;
    key_inc_p  = i;
    load_en    = l;
    load_data  = d;
    step();
    key_mode_p = 1'b0;
    key_inc_p  = 1'b0;
    load_en    = 1'b0;
  endtask

  // Steps until sec_tick (at most max cycles); reports the cycle count, 0 if none.
  task automatic run_to_tick(input string name, input int max, input int exp_n);
    int n = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sec_tick) begin
        n = i;
        break;
      end
    end
    check(name, 24'(n), 24'(exp_n));
  endtask

  task automatic count_ticks(input string name, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (sec_tick) n++;
    end
    check(name, 24'(n), 24'd0);
  endtask

  initial begin
    int last;
    int ticks;

    // reset state
    En = 1'b1;
    step();
    step();
    check("reset_time", time_data, 24'h000000);
    check("reset_state", 24'(set_state), 24'd0);
    check("reset_tick", 24'(sec_tick), 24'd0);
    check("reset_err", 24'(load_err), 24'd0);

    // 600 cycles of free running: 60 ticks, 10 cycles apart
    for (int k = 1; k <= 60; k++) exp_q.push_back({8'h00, 8'(k / 60), 8'(k % 60)});
    Rst_n = 1'b1;
    last = 0;
    ticks = 0;
    for (int i = 1; i <= 600; i++) begin
      step();
      if (sec_tick) begin
        ticks++;
        check("tick_spacing", 24'(i - last), 24'd10);
        last = i;
        if (exp_q.size() > 0) check("tick_time", time_data, exp_q.pop_front());
        else check("extra_tick", 24'(ticks), 24'd60);
      end
    end
    check("tick_count", 24'(ticks), 24'd60);
    check("run_600_time", time_data, 24'h000100);
    check("queue_drained", 24'(exp_q.size()), 24'd0);

    // full-day rollover and 12-hour rejection
    pulse(1'b0, 1'b0, 1'b1, 24'h173B3B);
    check("load_235959", time_data, 24'h173B3B);
    check("load_ok_err", 24'(load_err), 24'd0);
    check("load12_err", 24'(err12), 24'd1);
    run_to_tick("rollover_lat", 12, 10);
    check("rollover_time", time_data, 24'h000000);
    check("load12_err_drop", 24'(err12), 24'd0);

    // En pause mid-count
    count_ticks("pre_pause", 4);
    En = 1'b0;
    count_ticks("paused", 37);
    En = 1'b1;
    run_to_tick("resume_lat", 20, 6);
    check("resume_time", time_data, 24'h000001);

    // manual setting sequence
    pulse(1'b1, 1'b0, 1'b0, 24'h0);
    check("set_hour_state", 24'(set_state), 24'd1);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b0, 24'h0);
    check("hour_x5", time_data, 24'h050001);
    pulse(1'b1, 1'b0, 1'b0, 24'h0);
    check("set_min_state", 24'(set_state), 24'd2);
    for (int i = 0; i < 61; i++) pulse(1'b0, 1'b1, 1'b0, 24'h0);
    check("min_x61", time_data, 24'h050101);
    pulse(1'b1, 1'b0, 1'b0, 24'h0);
    check("set_sec_state", 24'(set_state), 24'd3);
    pulse(1'b0, 1'b1, 1'b0, 24'h0);
    check("sec_clear", time_data, 24'h050100);
    pulse(1'b1, 1'b0, 1'b0, 24'h0);
    check("back_to_run", 24'(set_state), 24'd0);
    run_to_tick("restart_lat", 20, 10);
    check("restart_time", time_data, 24'h050101);

    // load coinciding with tick
    count_ticks("pre_collide", 9);
    pulse(1'b0, 1'b0, 1'b1, 24'h0A0B0C);
    check("collide_time", time_data, 24'h0A0B0C);
    check("collide_tick", 24'(sec_tick), 24'd0);
    run_to_tick("post_load_lat", 20, 10);
    check("post_load_time", time_data, 24'h0A0B0D);

    // table-driven set/load vectors with the prescaler frozen
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 24'h0C2238, 24'h0C2238, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 24'h180000, 24'h0C2238, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 24'h003C00, 24'h0C2238, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h0C2238, 2'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h0D2238, 2'd1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 24'h0D2238, 2'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h0D2338, 2'd2, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h0D2338, 2'd3, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h0D2300, 2'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h0D2300, 2'd3, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h0D2300, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h0D2300, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 24'h173B3B, 24'h173B3B, 2'd0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h173B3B, 2'd1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h003B3B, 2'd1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h003B3B, 2'd2, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h00003B, 2'd2, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 24'h010203, 24'h010203, 2'd0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 24'h050607, 24'h050607, 2'd0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 24'h3F3F3F, 24'h050607, 2'd0, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h050607, 2'd1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 24'h00003C, 24'h050607, 2'd1, 1'b1};
    En = 1'b0;
    for (int v = 0; v < 22; v++) begin
      pulse(vecs[v].mode, vecs[v].inc, vecs[v].load, vecs[v].data);
      check($sformatf("vec%0d_time", v), time_data, vecs[v].exp_time);
      check($sformatf("vec%0d_state", v), 24'(set_state), 24'(vecs[v].exp_state));
      check($sformatf("vec%0d_err", v), 24'(load_err), 24'(vecs[v].exp_err));
      check($sformatf("vec%0d_tick", v), 24'(sec_tick), 24'd0);
    end

    // asynchronous reset mid-count
    En = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 24'h0C2238);
    check("pre_reset_time", time_data, 24'h0C2238);
    step();
    step();
    step();
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_rst_time", time_data, 24'h000000);
    check("async_rst_state", 24'(set_state), 24'd0);
    check("async_rst_tick", 24'(sec_tick), 24'd0);
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    run_to_tick("post_rst_lat", 20, 10);
    check("post_rst_time", time_data, 24'h000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
